// File: rtl/fp_align_unpack.sv
// fp_align_unpack: front end of the FP adder datapath.
// Captures two IEEE-754 single operands, classifies them, orders them by
// magnitude and right-aligns the smaller significand to the larger exponent
// with sticky accumulation. Results are held in DONE until the normalize
// stage accepts them.
// Optional feature: define ALIGN_FASTSHIFT_EN to replace the iterative SHIFT
// state with a single-cycle barrel shift performed in UNPACK.
module fp_align_unpack #(
  parameter int SHIFT_STEP    = 4,   // max right-shift bits per SHIFT cycle (1..32)
  parameter int BYPASS_THRESH = 26   // exponent gap at which the small addend is dropped
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        signA,
  output logic        signB,
  output logic [31:0] alignedBig,
  output logic [31:0] alignedSmall,
  output logic        swapped,
  output logic [7:0]  exponentOut,
  output logic        sticky,
  output logic        ANaN,
  output logic        BNaN,
  output logic        Ainf,
  output logic        Binf,
  output logic        Azero,
  output logic        Bzero,
  output logic        Asub,
  output logic        Bsub,
  output logic        bypassALU,
  output logic        Aex,
  output logic        Bex
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UNPACK = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sign_a, r_sign_b;
  logic [31:0] r_aligned_big;
  logic [31:0] r_aligned_small;
  logic        r_swapped;
  logic [7:0]  r_exponent;
  logic        r_sticky;
  logic        r_a_nan, r_b_nan, r_a_inf, r_b_inf;
  logic        r_a_zero, r_b_zero, r_a_sub, r_b_sub;
  logic        r_bypass, r_a_ex, r_b_ex;

  // ---------------------------------------------------------------------------
  // Operand classification and magnitude ordering (valid while in UNPACK)
  // ---------------------------------------------------------------------------
  logic [7:0]  w_exp_a, w_exp_b;
  logic [22:0] w_frac_a, w_frac_b;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_a_zero, w_b_zero, w_a_sub, w_b_sub;
  logic [7:0]  w_eff_a, w_eff_b;
  logic [31:0] w_sig_a, w_sig_b;
  logic        w_a_big;
  logic [31:0] w_sig_big, w_sig_small;
  logic [7:0]  w_exp_big;
  logic [7:0]  w_diff;
  logic        w_special;
  logic        w_bypass;

  assign w_exp_a  = r_a[30:23];
  assign w_exp_b  = r_b[30:23];
  assign w_frac_a = r_a[22:0];
  assign w_frac_b = r_b[22:0];

  assign w_a_nan  = (w_exp_a == 8'hFF) && (w_frac_a != 23'd0);
  assign w_b_nan  = (w_exp_b == 8'hFF) && (w_frac_b != 23'd0);
  assign w_a_inf  = (w_exp_a == 8'hFF) && (w_frac_a == 23'd0);
  assign w_b_inf  = (w_exp_b == 8'hFF) && (w_frac_b == 23'd0);
  assign w_a_zero = (w_exp_a == 8'h00) && (w_frac_a == 23'd0);
  assign w_b_zero = (w_exp_b == 8'h00) && (w_frac_b == 23'd0);
  assign w_a_sub  = (w_exp_a == 8'h00) && (w_frac_a != 23'd0);
  assign w_b_sub  = (w_exp_b == 8'h00) && (w_frac_b != 23'd0);

  // Subnormals (and zero) behave as exponent 1 with no hidden bit.
  assign w_eff_a = (w_exp_a == 8'h00) ? 8'd1 : w_exp_a;
  assign w_eff_b = (w_exp_b == 8'h00) ? 8'd1 : w_exp_b;
  assign w_sig_a = {(w_exp_a != 8'h00), w_frac_a, 8'h00};
  assign w_sig_b = {(w_exp_b != 8'h00), w_frac_b, 8'h00};

  // Ties on exponent go to the larger fraction; full ties keep A as big.
  assign w_a_big = (w_eff_a > w_eff_b) ||
                   ((w_eff_a == w_eff_b) && (w_frac_a >= w_frac_b));

  assign w_sig_big   = w_a_big ? w_sig_a : w_sig_b;
  assign w_sig_small = w_a_big ? w_sig_b : w_sig_a;
  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_diff      = w_a_big ? (w_eff_a - w_eff_b) : (w_eff_b - w_eff_a);

  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_bypass  = int'(w_diff) >= BYPASS_THRESH;

`ifdef ALIGN_FASTSHIFT_EN
  // ---------------------------------------------------------------------------
  // Single-cycle barrel shift by the full exponent difference. The low half of
  // the 64-bit window collects the bits that fall off the bottom.
  // ---------------------------------------------------------------------------
  logic [63:0] w_fast_wide;
  logic [31:0] w_fast_small;
  logic        w_fast_sticky;

  assign w_fast_wide   = {w_sig_small, 32'h0} >> w_diff;
  assign w_fast_small  = (w_diff >= 8'd32) ? 32'h0 : w_fast_wide[63:32];
  assign w_fast_sticky = (w_diff >= 8'd32) ? (|w_sig_small) : (|w_fast_wide[31:0]);
`else
  // ---------------------------------------------------------------------------
  // Iterative shifter: one step of at most SHIFT_STEP bits per SHIFT cycle.
  // ---------------------------------------------------------------------------
  localparam logic [7:0] STEP_MAX = 8'(SHIFT_STEP);

  logic [7:0]  r_remain;
  logic [7:0]  w_step;
  logic [63:0] w_step_wide;

  assign w_step      = (r_remain < STEP_MAX) ? r_remain : STEP_MAX;
  assign w_step_wide = {r_aligned_small, 32'h0} >> w_step;
`endif

  // ---------------------------------------------------------------------------
  // Handshake status is a pure function of the state register.
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  assign signA        = r_sign_a;
  assign signB        = r_sign_b;
  assign alignedBig   = r_aligned_big;
  assign alignedSmall = r_aligned_small;
  assign swapped      = r_swapped;
  assign exponentOut  = r_exponent;
  assign sticky       = r_sticky;
  assign ANaN         = r_a_nan;
  assign BNaN         = r_b_nan;
  assign Ainf         = r_a_inf;
  assign Binf         = r_b_inf;
  assign Azero        = r_a_zero;
  assign Bzero        = r_b_zero;
  assign Asub         = r_a_sub;
  assign Bsub         = r_b_sub;
  assign bypassALU    = r_bypass;
  assign Aex          = r_a_ex;
  assign Bex          = r_b_ex;

  // FSM and result registers: capture in IDLE, classify in UNPACK, align in
  // SHIFT, hold in DONE until the consumer takes the result.
  // NOTE: every register here uses <= so all updates in a cycle see the old
  // values; reset is asynchronous so an in-flight operation is dropped at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_a             <= 32'h0;
      r_b             <= 32'h0;
      r_sign_a        <= 1'b0;
      r_sign_b        <= 1'b0;
      r_aligned_big   <= 32'h0;
      r_aligned_small <= 32'h0;
      r_swapped       <= 1'b0;
      r_exponent      <= 8'h0;
      r_sticky        <= 1'b0;
      r_a_nan         <= 1'b0;
      r_b_nan         <= 1'b0;
      r_a_inf         <= 1'b0;
      r_b_inf         <= 1'b0;
      r_a_zero        <= 1'b0;
      r_b_zero        <= 1'b0;
      r_a_sub         <= 1'b0;
      r_b_sub         <= 1'b0;
      r_bypass        <= 1'b0;
      r_a_ex          <= 1'b0;
      r_b_ex          <= 1'b0;
`ifndef ALIGN_FASTSHIFT_EN
      r_remain        <= 8'h0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_state <= UNPACK;
          end
        end

        UNPACK: begin
          r_sign_a      <= r_a[31];
          r_sign_b      <= r_b[31];
          r_a_nan       <= w_a_nan;
          r_b_nan       <= w_b_nan;
          r_a_inf       <= w_a_inf;
          r_b_inf       <= w_b_inf;
          r_a_zero      <= w_a_zero;
          r_b_zero      <= w_b_zero;
          r_a_sub       <= w_a_sub;
          r_b_sub       <= w_b_sub;
          r_swapped     <= ~w_a_big;
          r_aligned_big <= w_sig_big;
          r_exponent    <= w_exp_big;
          r_bypass      <= 1'b0;
          r_a_ex        <= 1'b0;
          r_b_ex        <= 1'b0;
          r_sticky      <= 1'b0;
          if (w_special || (w_diff == 8'd0)) begin
            r_aligned_small <= w_sig_small;
            r_state         <= DONE;
          end else if (w_bypass) begin
            // Small addend lies wholly below the sticky position.
            r_bypass        <= 1'b1;
            r_a_ex          <= w_a_big;
            r_b_ex          <= ~w_a_big;
            r_aligned_small <= 32'h0;
            r_sticky        <= |w_sig_small;
            r_state         <= DONE;
          end else begin
`ifdef ALIGN_FASTSHIFT_EN
            r_aligned_small <= w_fast_small;
            r_sticky        <= w_fast_sticky;
            r_state         <= DONE;
`else
            r_aligned_small <= w_sig_small;
            r_remain        <= w_diff;
            r_state         <= SHIFT;
`endif
          end
        end

`ifndef ALIGN_FASTSHIFT_EN
        SHIFT: begin
          r_aligned_small <= w_step_wide[63:32];
          r_sticky        <= r_sticky | (|w_step_wide[31:0]);
          r_remain        <= r_remain - w_step;
          if (r_remain == w_step) begin
            r_state <= DONE;
          end
        end
`endif

        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_unpack.sv
// Directed self-checking bench for fp_align_unpack (default build: iterative
// shifter, SHIFT_STEP=4, BYPASS_THRESH=26). Latency is counted in clock edges
// from the accepting edge (inclusive) to the edge after which out_valid is high.
module tb_fp_align_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic        signA, signB;
  logic [31:0] alignedBig, alignedSmall;
  logic        swapped;
  logic [7:0]  exponentOut;
  logic        sticky;
  logic        ANaN, BNaN, Ainf, Binf, Azero, Bzero, Asub, Bsub;
  logic        bypassALU, Aex, Bex;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  logic [31:0] hold_big, hold_small;

  fp_align_unpack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .signA(signA), .signB(signB), .alignedBig(alignedBig),
    .alignedSmall(alignedSmall), .swapped(swapped), .exponentOut(exponentOut),
    .sticky(sticky), .ANaN(ANaN), .BNaN(BNaN), .Ainf(Ainf), .Binf(Binf),
    .Azero(Azero), .Bzero(Bzero), .Asub(Asub), .Bsub(Bsub),
    .bypassALU(bypassALU), .Aex(Aex), .Bex(Bex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present one pair, then count edges until out_valid is seen (bounded).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int l);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    l = 1;
    @(negedge clk);
    while (!out_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  // Accept the result and confirm the handshake returns the block to IDLE.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ov_drop"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 32'h0; B = 32'h0;
    #12;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_big", alignedBig, 32'h0);
    check("rst_small", alignedSmall, 32'h0);
    check("rst_flags", {18'h0, sticky, swapped, ANaN, BNaN, Ainf, Binf,
                        Azero, Bzero, Asub, Bsub, bypassALU, Aex, Bex, signA}, 32'h0);
    @(negedge clk); reset = 1'b0;

    // 1.0 + 0.5: d=1, one shift step
    issue(32'h3F800000, 32'h3F000000, lat);
    check("c1_lat", lat, 3);
    check("c1_big", alignedBig, 32'h80000000);
    check("c1_small", alignedSmall, 32'h40000000);
    check("c1_exp", {24'h0, exponentOut}, 32'h7F);
    check("c1_sticky", {31'h0, sticky}, 32'h0);
    check("c1_swapped", {31'h0, swapped}, 32'h0);

    // Hold in DONE with out_ready low; in_valid must be ignored meanwhile
    hold_big = alignedBig; hold_small = alignedSmall;
    in_valid = 1'b1; A = 32'h40400000; B = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ov", {31'h0, out_valid}, 32'h1);
      check("hold_ir", {31'h0, in_ready}, 32'h0);
      check("hold_big", alignedBig, hold_big);
      check("hold_small", alignedSmall, hold_small);
    end
    in_valid = 1'b0;
    consume("c1");

    // B much larger: swapped, d=10, sticky from the LSB of A
    issue(32'h3F800001, 32'h44800000, lat);
    check("c2_lat", lat, 5);
    check("c2_swapped", {31'h0, swapped}, 32'h1);
    check("c2_exp", {24'h0, exponentOut}, 32'h89);
    check("c2_big", alignedBig, 32'h80000000);
    check("c2_small", alignedSmall, 32'h00200000);
    check("c2_sticky", {31'h0, sticky}, 32'h1);
    consume("c2");

    // NaN operand: no shift
    issue(32'h7FC00000, 32'h3F800000, lat);
    check("c3_lat", lat, 2);
    check("c3_nan", {30'h0, ANaN, BNaN}, 32'h2);
    check("c3_exp", {24'h0, exponentOut}, 32'hFF);
    check("c3_sticky", {31'h0, sticky}, 32'h0);
    consume("c3");

    // Bypass boundary: d=24, d=25 shift; d=26 bypasses
    issue(32'h4B800000, 32'h3F800000, lat);
    check("d24_lat", lat, 8);
    check("d24_small", alignedSmall, 32'h00000080);
    check("d24_bypass", {29'h0, bypassALU, Aex, Bex}, 32'h0);
    consume("d24");

    issue(32'h4C000000, 32'h3F800000, lat);
    check("d25_lat", lat, 9);
    check("d25_small", alignedSmall, 32'h00000040);
    check("d25_bypass", {29'h0, bypassALU, Aex, Bex}, 32'h0);
    consume("d25");

    issue(32'h4C800000, 32'h3F800000, lat);
    check("d26_lat", lat, 2);
    check("d26_bypass", {29'h0, bypassALU, Aex, Bex}, 32'h6);
    check("d26_exp", {24'h0, exponentOut}, 32'h99);
    consume("d26");

    // Two subnormals, equal effective exponent, B has larger fraction
    issue(32'h00000001, 32'h00000003, lat);
    check("sub_lat", lat, 2);
    check("sub_flags", {30'h0, Asub, Bsub}, 32'h3);
    check("sub_zero", {30'h0, Azero, Bzero}, 32'h0);
    check("sub_swapped", {31'h0, swapped}, 32'h1);
    check("sub_big", alignedBig, 32'h00000300);
    check("sub_small", alignedSmall, 32'h00000100);
    check("sub_exp", {24'h0, exponentOut}, 32'h00);
    consume("sub");

    // Negative signs captured
    issue(32'hC0000000, 32'hBF800000, lat);
    check("sgn_lat", lat, 3);
    check("sgn_bits", {30'h0, signA, signB}, 32'h3);
    check("sgn_small", alignedSmall, 32'h40000000);
    consume("sgn");

    // Reset while in SHIFT
    @(negedge clk);
    A = 32'h3F800001; B = 32'h44800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ov", {31'h0, out_valid}, 32'h0);
    check("mid_rst_ir", {31'h0, in_ready}, 32'h1);
    check("mid_rst_big", alignedBig, 32'h0);
    check("mid_rst_sticky", {31'h0, sticky}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ir", {31'h0, in_ready}, 32'h1);
    check("post_rst_ov", {31'h0, out_valid}, 32'h0);

    // Recovery after reset
    issue(32'h3F800000, 32'h3F000000, lat);
    check("rec_lat", lat, 3);
    check("rec_small", alignedSmall, 32'h40000000);
    consume("rec");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_align_unpack.md
Name: fp_align_unpack

Overview:
- Front end of the FP adder datapath; the normalize stage is its consumer.
- Accepts two packed IEEE-754 single-precision operands over a valid/ready handshake.
- Classifies each operand and orders them by magnitude.
- Right-shifts the smaller significand iteratively to the larger exponent, accumulating sticky. Presents aligned significands, exponent and flags to the ALU/normalize stages.

Parameters:
- SHIFT_STEP, 4, maximum right-shift bits applied per SHIFT cycle (1..32).
- BYPASS_THRESH, 26, effective exponent difference at or above which the smaller addend is declared insignificant.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept; equals (state==IDLE).
- A  input  32  operand A, IEEE-754 single.
- B  input  32  operand B, IEEE-754 single.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts result.
- signA, signB  output  1 each  captured sign bits.
- alignedBig  output  32  larger-magnitude significand {hidden, frac[22:0], 8'b0}.
- alignedSmall  output  32  smaller significand, right-shifted by the exponent difference.
- swapped  output  1  1 when B is the larger-magnitude operand.
- exponentOut  output  8  larger raw exponent field.
- sticky  output  1  OR of all bits shifted out below bit 0 of alignedSmall.
- ANaN, BNaN, Ainf, Binf, Azero, Bzero, Asub, Bsub  output  1 each  per-operand class.
- bypassALU  output  1  smaller addend insignificant.
- Aex, Bex  output  1 each  A (resp. B) is the surviving operand when bypassALU=1.

Behaviour:
- Reset (async): state=IDLE. All outputs 0 except in_ready=1. Any in-flight operation is discarded.
- FSM states: IDLE, UNPACK, SHIFT, DONE.
- IDLE:
  - A transfer occurs when in_valid && in_ready; A and B are registered and the FSM goes to UNPACK.
  - in_valid is ignored in every state other than IDLE.
- UNPACK (1 cycle): classify each operand.
  - exp=FF, frac!=0: NaN.
  - exp=FF, frac=0: inf.
  - exp=0, frac=0: zero.
  - exp=0, frac!=0: sub; effective exponent 1, hidden bit 0.
  - otherwise normal; hidden bit 1.
- Ordering:
  - big=A if effA>effB, or effA==effB and fracA>=fracB; otherwise big=B and swapped=1.
  - d = effBig - effSmall.
- Routing out of UNPACK:
  - If any NaN/inf/zero flag is set, or d==0: go to DONE with no shift and sticky=0.
  - Else if d>=BYPASS_THRESH: set bypassALU=1, set Aex/Bex for the big operand, go to DONE.
  - Otherwise go to SHIFT with remaining=d.
- SHIFT: each cycle shifts alignedSmall right by s=min(remaining, SHIFT_STEP).
  - sticky |= OR of the s bits shifted out; remaining -= s.
  - Exits to DONE when remaining reaches 0.
  - Shift amounts >=32 leave alignedSmall=0 with sticky=|original significand (unreachable at default BYPASS_THRESH).
- DONE: out_valid=1. All outputs are held stable until out_ready=1, then the FSM returns to IDLE. out_valid deasserts the cycle after the handshake.
- Latency, acceptance edge to out_valid high: 2 cycles when no shift; otherwise 2+ceil(d/SHIFT_STEP) cycles.
- Throughput: one pair per (latency+1) cycles minimum; in_ready is high only in IDLE.
- Output fields are registered and change only on the UNPACK/SHIFT edges; they are undefined-free (0) before the first operation.

Optional Feature:
- ALIGN_FASTSHIFT_EN: when defined, the SHIFT state is removed. UNPACK performs a single-cycle barrel shift by d, with sticky computed by masking the low d bits, and proceeds directly to DONE. Latency is a constant 2 cycles.
- When not defined, the iterative SHIFT_STEP shifter described above is used.

Test Plan:
- A=3F800000, B=3F000000, default params -> out_valid 3 cycles after accept; alignedBig=80000000, alignedSmall=40000000, exponentOut=7F, sticky=0, swapped=0.
- A=3F800001, B=44800000 -> swapped=1, exponentOut=89, d=10, alignedSmall=00200000, sticky=1; out_valid 5 cycles after accept.
- A=7FC00000, B=3F800000 -> ANaN=1; out_valid 2 cycles after accept; no SHIFT state entered.
- A=4B800000, B=3F800000 (d=24 -> no bypass), then A=4C000000, B=3F800000 (d=25 -> no bypass), then A=4C800000 (d=26) -> bypassALU=1, Aex=1, Bex=0.
- A=00000001, B=00000003 -> Asub=Bsub=1, d=0, swapped=1, alignedBig=00000300, alignedSmall=00000100.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; assert reset mid-SHIFT -> next cycle state IDLE, out_valid=0, in_ready=1.
